// File: rtl/cov_mat_restore_pkg.sv
// Controller types for the rank-one covariance restoration engine.
package cov_mat_restore_pkg;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_e;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fp_double.sv
// Shared IEEE-754 binary64 type and round-to-nearest-even arithmetic.
// Pure functions, so every operator is combinational wherever it is used.
package fp_double;

  typedef logic [63:0] double_t;

  localparam double_t DBL_QNAN = 64'h7FF8_0000_0000_0000;
  localparam double_t DBL_QBIT = 64'h0008_0000_0000_0000;

  function automatic int tri_count(input int n);
    return n * (n + 1) / 2;
  endfunction

  function automatic logic is_nan(input double_t x);
    return (&x[62:52]) && (|x[51:0]);
  endfunction

  function automatic logic is_inf(input double_t x);
    return (&x[62:52]) && !(|x[51:0]);
  endfunction

  function automatic logic [127:0] shr_sticky(input logic [127:0] x, input int sh);
    logic [127:0] r;
    logic         st;
    if (sh >= 128) begin
      r  = '0;
      st = |x;
    end else begin
      r  = x >> sh;
      st = |(x & ~({128{1'b1}} << sh));
    end
    r[0] = r[0] | st;
    return r;
  endfunction

  // sig is a fraction with its binary point above bit 127; value = sig/2^127 * 2^(e-1023).
  function automatic double_t round_pack(input logic s, input int e, input logic [127:0] sig);
    int          lz;
    int          ex;
    logic [127:0] m;
    logic        rnd;
    logic [62:0] mag;
    if (sig == '0) return {s, 63'd0};
    lz = 0;
    for (int k = 0; k < 128; k++) if (sig[k]) lz = 127 - k;
    m  = sig << lz;
    ex = e - lz;
    if (ex >= 2047) return {s, 11'h7FF, 52'd0};
    if (ex <= 0) begin
      m  = shr_sticky(m, 1 - ex);
      ex = 0;
    end
    // A carry out of the mantissa bumps the exponent field, covering subnormal->normal and overflow->inf.
    rnd = m[74] & (m[75] | (|m[73:0]));
    mag = {ex[10:0], m[126:75]} + {62'd0, rnd};
    return {s, mag};
  endfunction

  function automatic double_t fp_mul(input double_t a, input double_t b);
    logic         s;
    logic [52:0]  ma, mb;
    logic [105:0] p;
    int           ea, eb;
    s = a[63] ^ b[63];
    if (is_nan(a)) return a | DBL_QBIT;
    if (is_nan(b)) return b | DBL_QBIT;
    if (is_inf(a) || is_inf(b)) begin
      if (a[62:0] == '0 || b[62:0] == '0) return DBL_QNAN;
      return {s, 11'h7FF, 52'd0};
    end
    ma = {|a[62:52], a[51:0]};
    mb = {|b[62:52], b[51:0]};
    ea = (a[62:52] == 11'd0) ? 1 : int'(a[62:52]);
    eb = (b[62:52] == 11'd0) ? 1 : int'(b[62:52]);
    p  = 106'(ma) * 106'(mb);
    return round_pack(s, ea + eb - 1022, {p, 22'd0});
  endfunction

  function automatic double_t fp_add(input double_t a, input double_t b);
    double_t      x, y;
    logic [127:0] mx, my, sum;
    int           ex, ey;
    logic         s;
    if (is_nan(a)) return a | DBL_QBIT;
    if (is_nan(b)) return b | DBL_QBIT;
    if (is_inf(a) && is_inf(b) && (a[63] != b[63])) return DBL_QNAN;
    if (is_inf(a)) return a;
    if (is_inf(b)) return b;
    // Order by magnitude so the aligned difference is never negative.
    if (a[62:0] >= b[62:0]) begin
      x = a; y = b;
    end else begin
      x = b; y = a;
    end
    ex = (x[62:52] == 11'd0) ? 1 : int'(x[62:52]);
    ey = (y[62:52] == 11'd0) ? 1 : int'(y[62:52]);
    mx = {1'b0, |x[62:52], x[51:0], 74'd0};
    my = shr_sticky({1'b0, |y[62:52], y[51:0], 74'd0}, ex - ey);
    if (x[63] == y[63]) begin
      sum = mx + my;
      s   = x[63];
    end else begin
      sum = mx - my;
      s   = (sum == '0) ? 1'b0 : x[63];
    end
    return round_pack(s, ex + 1, sum);
  endfunction

endpackage

// File: rtl/rank1_elem_pipe.sv
// One element r = ((lambda*v_i)*v_j) + c_ij per cycle, PIPE_LAT cycles to output.
// No backpressure; indices ride with the data so write-back needs no bookkeeping.
module rank1_elem_pipe
  import fp_double::*;
#(
  parameter int PIPE_LAT = 4,
  parameter int IW       = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          valid,
  input  double_t       lambda,
  input  double_t       v_i,
  input  double_t       v_j,
  input  double_t       c_ij,
  input  logic [IW-1:0] i,
  input  logic [IW-1:0] j,
  output logic          valid_out,
  output double_t       r,
  output logic [IW-1:0] i_out,
  output logic [IW-1:0] j_out
);

  double_t       r_d;
  logic          vld_q [PIPE_LAT];
  double_t       r_q   [PIPE_LAT];
  logic [IW-1:0] i_q   [PIPE_LAT];
  logic [IW-1:0] j_q   [PIPE_LAT];

  assign r_d = fp_add(fp_mul(fp_mul(lambda, v_i), v_j), c_ij);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < PIPE_LAT; k++) vld_q[k] <= 1'b0;
    end else begin
      vld_q[0] <= valid;
      for (int k = 1; k < PIPE_LAT; k++) vld_q[k] <= vld_q[k-1];
    end
  end

  // Payload only moves with a valid token; idle stages keep their old contents.
  always_ff @(posedge clk) begin
    if (valid) begin
      r_q[0] <= r_d;
      i_q[0] <= i;
      j_q[0] <= j;
    end
    for (int k = 1; k < PIPE_LAT; k++) begin
      if (vld_q[k-1]) begin
        r_q[k] <= r_q[k-1];
        i_q[k] <= i_q[k-1];
        j_q[k] <= j_q[k-1];
      end
    end
  end

  assign valid_out = vld_q[PIPE_LAT-1];
  assign r         = r_q[PIPE_LAT-1];
  assign i_out     = i_q[PIPE_LAT-1];
  assign j_out     = j_q[PIPE_LAT-1];

endmodule

// File: rtl/cov_mat_restore.sv
// C_out = C_in + lambda*v*v^T over the upper triangle, mirrored; start->f is tri_count(N)+PIPE_LAT+1 cycles.
// No backpressure: start is only honoured in IDLE and ignored otherwise.
module cov_mat_restore
  import fp_double::*;
  import cov_mat_restore_pkg::*;
#(
  parameter int SIZE_N   = 8,
  parameter int PIPE_LAT = 4
) (
  input  logic    clk,
  input  logic    rst,
  input  logic    start,
  input  double_t vector         [SIZE_N],
  input  double_t eigenvalue,
  input  double_t cov_matrix_in  [SIZE_N][SIZE_N],
  output double_t cov_matrix_out [SIZE_N][SIZE_N],
  output logic    busy,
  output logic    f
);

  localparam int            IW   = idx_w(SIZE_N);
  localparam int            CW   = idx_w(PIPE_LAT);
  localparam logic [IW-1:0] LAST = IW'(SIZE_N - 1);
  localparam logic [CW-1:0] DMAX = CW'(PIPE_LAT - 1);

  state_e        state, state_nxt;
  logic [IW-1:0] i_q, j_q, i_nxt, j_nxt;
  logic [CW-1:0] cnt_q, cnt_nxt;
  logic          latch_en, issue;

  double_t       lam_q;
  double_t       vec_q [SIZE_N];
  double_t       cin_q [SIZE_N][SIZE_N];

  logic          wb_vld;
  double_t       wb_r;
  logic [IW-1:0] wb_i, wb_j;

  always_comb begin
    state_nxt = state;
    i_nxt     = i_q;
    j_nxt     = j_q;
    cnt_nxt   = cnt_q;
    latch_en  = 1'b0;
    issue     = 1'b0;
    busy      = 1'b0;
    f         = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          latch_en  = 1'b1;
          i_nxt     = '0;
          j_nxt     = '0;
          state_nxt = S_ISSUE;
        end
      end
      S_ISSUE: begin
        busy  = 1'b1;
        issue = 1'b1;
        if (j_q == LAST) begin
          if (i_q == LAST) begin
            cnt_nxt   = '0;
            state_nxt = S_DRAIN;
          end else begin
            i_nxt = i_q + 1'b1;
            j_nxt = i_q + 1'b1;
          end
        end else begin
          j_nxt = j_q + 1'b1;
        end
      end
      S_DRAIN: begin
        busy = 1'b1;
        if (cnt_q == DMAX) state_nxt = S_DONE;
        else               cnt_nxt   = cnt_q + 1'b1;
      end
      S_DONE: begin
        f         = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      i_q   <= '0;
      j_q   <= '0;
      cnt_q <= '0;
    end else begin
      state <= state_nxt;
      i_q   <= i_nxt;
      j_q   <= j_nxt;
      cnt_q <= cnt_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (latch_en) begin
      lam_q <= eigenvalue;
      vec_q <= vector;
      cin_q <= cov_matrix_in;
    end
  end

  // Both halves read the upper-triangle c_ij, so the output is symmetric regardless of C_in.
  rank1_elem_pipe #(.PIPE_LAT(PIPE_LAT), .IW(IW)) u_pipe (
    .clk       (clk),
    .rst       (rst),
    .valid     (issue),
    .lambda    (lam_q),
    .v_i       (vec_q[i_q]),
    .v_j       (vec_q[j_q]),
    .c_ij      (cin_q[i_q][j_q]),
    .i         (i_q),
    .j         (j_q),
    .valid_out (wb_vld),
    .r         (wb_r),
    .i_out     (wb_i),
    .j_out     (wb_j)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int a = 0; a < SIZE_N; a++)
        for (int b = 0; b < SIZE_N; b++)
          cov_matrix_out[a][b] <= '0;
    end else if (wb_vld) begin
      cov_matrix_out[wb_i][wb_j] <= wb_r;
      cov_matrix_out[wb_j][wb_i] <= wb_r;
    end
  end

endmodule

// File: tb/tb_cov_mat_restore.sv
// Directed table plus random runs of cov_mat_restore, checked against a real-arithmetic model.
module tb_cov_mat_restore;

  localparam int N   = 4;
  localparam int P   = 4;
  localparam int K   = N * (N + 1) / 2;
  localparam int LAT = K + P + 1;

  logic        clk = 1'b0;
  logic        rst;
  logic        start4, start1;
  logic [63:0] vec4 [N];
  logic [63:0] lam4;
  logic [63:0] cin4 [N][N];
  logic [63:0] cout4 [N][N];
  logic        busy4, f4;
  logic [63:0] vec1 [1];
  logic [63:0] lam1;
  logic [63:0] cin1 [1][1];
  logic [63:0] cout1 [1][1];
  logic        busy1, f1;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  cov_mat_restore #(.SIZE_N(N), .PIPE_LAT(P)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .vector(vec4), .eigenvalue(lam4),
    .cov_matrix_in(cin4), .cov_matrix_out(cout4), .busy(busy4), .f(f4));

  cov_mat_restore #(.SIZE_N(1), .PIPE_LAT(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .vector(vec1), .eigenvalue(lam1),
    .cov_matrix_in(cin1), .cov_matrix_out(cout1), .busy(busy1), .f(f1));

  typedef struct {
    string name;
    real   lam;
    real   v [N];
    real   c [N][N];
    real   e [N][N];
  } rec_t;

  rec_t tbl [4];

  task automatic chk64(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic chk_int(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  // Element rule, evaluated with the simulator's binary64 arithmetic one operation at a time.
  function automatic logic [63:0] model_elem(input real lam, input real vi, input real vj, input real c);
    real t1, t2, t3;
    t1 = lam * vi;
    t2 = t1 * vj;
    t3 = t2 + c;
    return $realtobits(t3);
  endfunction

  function automatic real rnd_real();
    logic [63:0] b;
    if ($urandom_range(0, 7) == 0) return 0.0;
    b[63]    = 1'($urandom_range(0, 1));
    b[62:52] = 11'(1013 + $urandom_range(0, 20));
    b[51:32] = 20'($urandom);
    b[31:0]  = $urandom;
    return $bitstoreal(b);
  endfunction

  function automatic rec_t make_rand();
    rec_t r;
    r.name = "random";
    r.lam  = rnd_real();
    for (int i = 0; i < N; i++) r.v[i] = rnd_real();
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) r.c[i][j] = rnd_real();
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++)
        r.e[i][j] = $bitstoreal(model_elem(r.lam, r.v[(i < j) ? i : j], r.v[(i < j) ? j : i],
                                           r.c[(i < j) ? i : j][(i < j) ? j : i]));
    return r;
  endfunction

  task automatic load(input rec_t r);
    lam4 = $realtobits(r.lam);
    for (int i = 0; i < N; i++) begin
      vec4[i] = $realtobits(r.v[i]);
      for (int j = 0; j < N; j++) cin4[i][j] = $realtobits(r.c[i][j]);
    end
  endtask

  task automatic chk_mat(input rec_t r);
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++)
        chk64($sformatf("%s[%0d][%0d]", r.name, i, j), cout4[i][j], $realtobits(r.e[i][j]));
  endtask

  // Start with a's inputs, then hold b's inputs; optional extra start pulses at cycles s1/s2.
  task automatic run_op(input rec_t a, input rec_t b, input int s1, input int s2,
                        output int fcyc, output int nf);
    @(posedge clk); #1;
    load(a);
    start4 = 1'b1;
    fcyc = -1;
    nf   = 0;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      @(posedge clk); #1;
      start4 = 1'b0;
      load(b);
      if (cyc == s1 || cyc == s2) start4 = 1'b1;
      if (cyc == 1) chk_int({a.name, "_busy_c1"}, int'(busy4), 1);
      if (f4) begin
        nf++;
        if (fcyc < 0) begin
          fcyc = cyc;
          chk_int({a.name, "_busy_at_f"}, int'(busy4), 0);
        end
      end
    end
    start4 = 1'b0;
  endtask

  initial begin
    int   fc, nf, viol;
    rec_t junk;

    tbl[0].name = "identity";
    tbl[0].lam  = 2.0;
    tbl[0].v    = '{1.0, 0.0, 0.0, 0.0};
    tbl[0].c    = '{'{1.0, 0.0, 0.0, 0.0}, '{0.0, 1.0, 0.0, 0.0}, '{0.0, 0.0, 1.0, 0.0}, '{0.0, 0.0, 0.0, 1.0}};
    tbl[0].e    = '{'{3.0, 0.0, 0.0, 0.0}, '{0.0, 1.0, 0.0, 0.0}, '{0.0, 0.0, 1.0, 0.0}, '{0.0, 0.0, 0.0, 1.0}};

    tbl[1].name = "symmetry";
    tbl[1].lam  = 0.5;
    tbl[1].v    = '{1.0, 2.0, 3.0, 4.0};
    tbl[1].c    = '{'{0.0, 0.0, 0.0, 0.0}, '{0.0, 0.0, 0.0, 0.0}, '{0.0, 0.0, 0.0, 0.0}, '{0.0, 0.0, 0.0, 0.0}};
    tbl[1].e    = '{'{0.5, 1.0, 1.5, 2.0}, '{1.0, 2.0, 3.0, 4.0}, '{1.5, 3.0, 4.5, 6.0}, '{2.0, 4.0, 6.0, 8.0}};

    tbl[2].name = "roundtrip";
    tbl[2].lam  = 4.0;
    tbl[2].v    = '{0.5, 0.5, 0.0, 0.0};
    tbl[2].c    = '{'{1.0, 0.0, 0.0, 0.0}, '{0.0, 1.0, 0.0, 0.0}, '{0.0, 0.0, 0.0, 0.0}, '{0.0, 0.0, 0.0, 0.0}};
    tbl[2].e    = '{'{2.0, 1.0, 0.0, 0.0}, '{1.0, 2.0, 0.0, 0.0}, '{0.0, 0.0, 0.0, 0.0}, '{0.0, 0.0, 0.0, 0.0}};

    tbl[3].name = "upper_mirror";
    tbl[3].lam  = 1.0;
    tbl[3].v    = '{0.0, 0.0, 0.0, 0.0};
    tbl[3].c    = '{'{1.0, 2.0, 3.0, 4.0}, '{-5.0, 6.0, 7.0, 8.0}, '{-9.0, -10.0, 11.0, 12.0}, '{-13.0, -14.0, -15.0, 16.0}};
    tbl[3].e    = '{'{1.0, 2.0, 3.0, 4.0}, '{2.0, 6.0, 7.0, 8.0}, '{3.0, 7.0, 11.0, 12.0}, '{4.0, 8.0, 12.0, 16.0}};

    rst    = 1'b1;
    start4 = 1'b0;
    start1 = 1'b0;
    load(tbl[1]);
    lam1       = '0;
    vec1[0]    = '0;
    cin1[0][0] = '0;
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) chk64($sformatf("reset_out[%0d][%0d]", i, j), cout4[i][j], 64'h0);
    chk64("reset_out1", cout1[0][0], 64'h0);
    chk_int("reset_busy", int'(busy4), 0);
    chk_int("reset_f", int'(f4), 0);
    rst = 1'b0;

    for (int t = 0; t < 4; t++) begin
      junk = make_rand();
      run_op(tbl[t], junk, -1, -1, fc, nf);
      chk_int({tbl[t].name, "_latency"}, fc, LAT);
      chk_int({tbl[t].name, "_pulses"}, nf, 1);
      chk_mat(tbl[t]);
    end

    // Starts while busy and while in DONE must be ignored.
    run_op(tbl[0], tbl[1], 3, LAT, fc, nf);
    chk_int("busy_start_latency", fc, LAT);
    chk_int("busy_start_pulses", nf, 1);
    chk_mat(tbl[0]);

    for (int t = 0; t < 12; t++) begin
      rec_t r;
      r    = make_rand();
      junk = make_rand();
      run_op(r, junk, -1, -1, fc, nf);
      chk_int("random_latency", fc, LAT);
      chk_int("random_pulses", nf, 1);
      chk_mat(r);
    end

    // Reset in the middle of an operation.
    @(posedge clk); #1;
    load(tbl[1]);
    start4 = 1'b1;
    for (int cyc = 1; cyc <= 5; cyc++) begin
      @(posedge clk); #1;
      start4 = 1'b0;
    end
    rst = 1'b1;
    #1;
    chk_int("midrst_busy", int'(busy4), 0);
    chk_int("midrst_f", int'(f4), 0);
    repeat (2) @(posedge clk);
    #1;
    rst  = 1'b0;
    viol = 0;
    for (int cyc = 0; cyc < 20; cyc++) begin
      @(posedge clk); #1;
      if (f4 || busy4) viol++;
    end
    chk_int("midrst_quiet_cycles", viol, 0);
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) chk64($sformatf("midrst_out[%0d][%0d]", i, j), cout4[i][j], 64'h0);
    junk = make_rand();
    run_op(tbl[1], junk, -1, -1, fc, nf);
    chk_int("after_rst_latency", fc, LAT);
    chk_int("after_rst_pulses", nf, 1);
    chk_mat(tbl[1]);

    // N=1, PIPE_LAT=1 corner: -1*3*3 + 10 = 1, f three cycles after start.
    @(posedge clk); #1;
    lam1       = $realtobits(-1.0);
    vec1[0]    = $realtobits(3.0);
    cin1[0][0] = $realtobits(10.0);
    start1     = 1'b1;
    fc = -1;
    nf = 0;
    for (int cyc = 1; cyc <= 10; cyc++) begin
      @(posedge clk); #1;
      start1     = 1'b0;
      vec1[0]    = $realtobits(7.0);
      cin1[0][0] = $realtobits(-2.0);
      if (cyc == 1) chk_int("n1_busy_c1", int'(busy1), 1);
      if (f1) begin
        nf++;
        if (fc < 0) fc = cyc;
      end
    end
    chk_int("n1_latency", fc, 3);
    chk_int("n1_pulses", nf, 1);
    chk64("n1_out", cout1[0][0], $realtobits(1.0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
